// File: rtl/mod_wb_arb.sv
// GRF write-back arbiter: merges pipeline WB and mult/div results into one write port, parking
// losing mult/div writes in a small FIFO. Define WB_TRACE_EN to print every issued GRF write.
module mod_wb_arb #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    output logic        wb_stall,

    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    output logic        md_ready,

    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        pend_rs,
    output logic        pend_rt,

    output logic        grf_write,
    output logic [4:0]  grf_reg_in,
    output logic [31:0] grf_data_in,
    output logic [31:0] pc_now
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; used_q marks occupied slots, live_q clears when a younger write squashes one
    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [DEPTH-1:0] used_q, used_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [DEPTH-1:0] squash;

    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic             wb_req, md_req;
    logic             fifo_empty, fifo_full;
    logic             starve;
    logic             sel_pipe, sel_fifo, sel_direct;
    logic             pop, push, md_accept;
    logic             head_live;

    logic             grf_write_d;
    logic [4:0]       grf_reg_d;
    logic [31:0]      grf_data_d;
    logic [31:0]      pc_d;

    // Writes to $0 are architecturally void, so they never compete for a slot
    assign wb_req     = wb_valid && (wb_reg != 5'd0);
    assign md_req     = md_valid && (md_reg != 5'd0);

    assign fifo_empty = (count_q == CW'(0));
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign starve     = !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));
    assign head_live  = live_q[rd_ptr_q];

    assign sel_pipe   = !starve && wb_req;
    assign sel_fifo   = !starve && !wb_req && !fifo_empty;
    assign sel_direct = !starve && !wb_req && fifo_empty && md_req;
    assign pop        = starve || sel_fifo;

    assign wb_stall   = starve;
    assign md_ready   = !fifo_full || pop;
    assign md_accept  = md_valid && md_ready;
    assign push       = md_accept && md_req && !sel_direct;

    always_comb begin
        squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = sel_pipe && used_q[i] && (fifo_reg_q[i] == wb_reg);
        end
    end

    always_comb begin
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (used_q[i] && live_q[i] && (fifo_reg_q[i] == rs) && (rs != 5'd0)) begin
                pend_rs = 1'b1;
            end
            if (used_q[i] && live_q[i] && (fifo_reg_q[i] == rt) && (rt != 5'd0)) begin
                pend_rt = 1'b1;
            end
        end
    end

    always_comb begin
        used_d = used_q;
        live_d = live_q & ~squash;
        if (pop) begin
            used_d[rd_ptr_q] = 1'b0;
        end
        // On a full FIFO with a pop, wr_ptr == rd_ptr, so the push must win over the pop clear
        if (push) begin
            used_d[wr_ptr_q] = 1'b1;
            live_d[wr_ptr_q] = !(sel_pipe && (md_reg == wb_reg));
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q >= SW'(STARVE_LIMIT)) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        grf_write_d = 1'b0;
        grf_reg_d   = grf_reg_in;
        grf_data_d  = grf_data_in;
        pc_d        = pc_now;
        if (pop) begin
            if (head_live) begin
                grf_write_d = 1'b1;
                grf_reg_d   = fifo_reg_q[rd_ptr_q];
                grf_data_d  = fifo_data_q[rd_ptr_q];
                pc_d        = fifo_pc_q[rd_ptr_q];
            end
        end else if (sel_pipe) begin
            grf_write_d = 1'b1;
            grf_reg_d   = wb_reg;
            grf_data_d  = wb_data;
            pc_d        = wb_pc;
        end else if (sel_direct) begin
            grf_write_d = 1'b1;
            grf_reg_d   = md_reg;
            grf_data_d  = md_data;
            pc_d        = md_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            used_q      <= '0;
            live_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            grf_write   <= 1'b0;
            grf_reg_in  <= '0;
            grf_data_in <= '0;
            pc_now      <= '0;
        end else begin
            used_q      <= used_d;
            live_q      <= live_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            grf_write   <= grf_write_d;
            grf_reg_in  <= grf_reg_d;
            grf_data_in <= grf_data_d;
            pc_now      <= pc_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q              <= wr_ptr_q + PW'(1);
                fifo_reg_q[wr_ptr_q]  <= md_reg;
                fifo_data_q[wr_ptr_q] <= md_data;
                fifo_pc_q[wr_ptr_q]   <= md_pc;
            end
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_write) begin
            $display("%d@%h: $%d <= %h", $time, pc_now, grf_reg_in, grf_data_in);
        end
    end
`else
    // Trace disabled: no display logic compiled.
`endif

endmodule

// File: tb/tb_mod_wb_arb.sv
// Directed bench for mod_wb_arb: a queue-based model predicts every output each cycle,
// with literal expectations pinning the key scenarios.
module tb_mod_wb_arb;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, md_valid;
    logic [4:0]  wb_reg, md_reg, rs, rt;
    logic [31:0] wb_data, wb_pc, md_data, md_pc;
    logic        wb_stall, md_ready, pend_rs, pend_rt;
    logic        grf_write;
    logic [4:0]  grf_reg_in;
    logic [31:0] grf_data_in, pc_now;

    always #5 clk = ~clk;

    mod_wb_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_stall(wb_stall),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_pc(md_pc),
        .md_ready(md_ready),
        .rs(rs), .rt(rt), .pend_rs(pend_rs), .pend_rt(pend_rt),
        .grf_write(grf_write), .grf_reg_in(grf_reg_in), .grf_data_in(grf_data_in),
        .pc_now(pc_now)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] pc;
        logic        live;
    } ent_t;

    ent_t        q[$];
    int          cnt = 0;
    logic        e_w = 1'b0;
    logic [4:0]  e_r = '0;
    logic [31:0] e_d = '0;
    logic [31:0] e_p = '0;
    int          seen_fill = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic mpend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].live && q[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, compare everything against the model, then advance the model.
    task automatic cyc(input logic rst,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [31:0] wp,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdd,
                       input logic [31:0] mp,
                       input logic [4:0] qa, input logic [4:0] qb);
        logic wb_ok, starve, pop, direct, ready, take;
        int   n;
        ent_t h;
        @(negedge clk);
        reset = rst; wb_valid = wv; wb_reg = wr; wb_data = wd; wb_pc = wp;
        md_valid = mv; md_reg = mr; md_data = mdd; md_pc = mp; rs = qa; rt = qb;
        #1;
        chk("grf_write", grf_write, e_w);
        if (e_w) begin
            chk("grf_reg_in", grf_reg_in, e_r);
            chk("grf_data_in", grf_data_in, e_d);
            chk("pc_now", pc_now, e_p);
        end
        if (grf_write && grf_reg_in >= 5'd21 && grf_reg_in <= 5'd25) seen_fill++;

        n      = q.size();
        wb_ok  = wv && (wr != 5'd0);
        starve = (n > 0) && (cnt >= LIMIT);
        pop    = starve || (!wb_ok && n > 0);
        direct = !starve && !wb_ok && (n == 0) && mv && (mr != 5'd0);
        ready  = (n < DEPTH) || pop;
        take   = wb_ok && !starve;
        if (!rst) begin
            chk("wb_stall", wb_stall, starve);
            chk("md_ready", md_ready, ready);
            chk("pend_rs", pend_rs, mpend(qa));
            chk("pend_rt", pend_rt, mpend(qb));
        end

        if (rst) begin
            q.delete();
            cnt = 0;
            e_w = 1'b0;
        end else begin
            e_w = 1'b0;
            if (pop) begin
                h = q.pop_front();
                if (h.live) begin
                    e_w = 1'b1; e_r = h.r; e_d = h.d; e_p = h.pc;
                end
            end else if (take) begin
                e_w = 1'b1; e_r = wr; e_d = wd; e_p = wp;
            end else if (direct) begin
                e_w = 1'b1; e_r = mr; e_d = mdd; e_p = mp;
            end
            if (take) foreach (q[i]) if (q[i].r == wr) q[i].live = 1'b0;
            if (mv && ready && (mr != 5'd0) && !direct)
                q.push_back('{r: mr, d: mdd, pc: mp, live: !(take && mr == wr)});
            if (pop || n == 0) cnt = 0;
            else if (cnt < LIMIT) cnt = cnt + 1;
        end
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, qa, qb);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; md_valid = 1'b0; wb_reg = '0; md_reg = '0;
        wb_data = '0; wb_pc = '0; md_data = '0; md_pc = '0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        idle(5'd3, 5'd4);
        chk("rst_grf_write", grf_write, 1'b0);
        chk("rst_grf_reg", grf_reg_in, 5'd0);
        chk("rst_grf_data", grf_data_in, 32'd0);
        chk("rst_pc_now", pc_now, 32'd0);
        chk("rst_md_ready", md_ready, 1'b1);
        chk("rst_wb_stall", wb_stall, 1'b0);

        // Plain pipeline write
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        after_edge();
        chk("t1_write", grf_write, 1'b1);
        chk("t1_reg", grf_reg_in, 5'd5);
        chk("t1_data", grf_data_in, 32'h1234);
        chk("t1_pc", pc_now, 32'h3000);

        // Collision: pipeline wins, mult/div parked then drained
        cyc(1'b0, 1'b1, 5'd9, 32'h99, 32'h3004, 1'b1, 5'd8, 32'hAA, 32'h2000, 5'd8, 5'd0);
        after_edge();
        chk("t2_first_reg", grf_reg_in, 5'd9);
        idle(5'd8, 5'd0);
        chk("t2_pend_rs", pend_rs, 1'b1);
        after_edge();
        chk("t2_drain_write", grf_write, 1'b1);
        chk("t2_drain_reg", grf_reg_in, 5'd8);
        chk("t2_drain_data", grf_data_in, 32'hAA);
        chk("t2_drain_pc", pc_now, 32'h2000);
        idle(5'd0, 5'd0);

        // Starvation under continuous pipeline writes
        cyc(1'b0, 1'b1, 5'd12, 32'h12, 32'h3010, 1'b1, 5'd11, 32'hB0B, 32'h2100, 5'd11, 5'd0);
        for (int k = 0; k < LIMIT; k++) begin
            cyc(1'b0, 1'b1, 5'd13, 32'(k), 32'h3020, 1'b0, 5'd0, 32'd0, 32'd0, 5'd11, 5'd0);
            chk("t3_no_stall", wb_stall, 1'b0);
        end
        cyc(1'b0, 1'b1, 5'd13, 32'h77, 32'h3030, 1'b0, 5'd0, 32'd0, 32'd0, 5'd11, 5'd0);
        chk("t3_stall", wb_stall, 1'b1);
        after_edge();
        chk("t3_starve_reg", grf_reg_in, 5'd11);
        chk("t3_starve_data", grf_data_in, 32'hB0B);
        cyc(1'b0, 1'b1, 5'd13, 32'h77, 32'h3030, 1'b0, 5'd0, 32'd0, 32'd0, 5'd11, 5'd0);
        chk("t3_resume_stall", wb_stall, 1'b0);
        after_edge();
        chk("t3_resume_data", grf_data_in, 32'h77);
        idle(5'd0, 5'd0);

        // WAW squash of a parked entry
        cyc(1'b0, 1'b1, 5'd20, 32'h20, 32'h3040, 1'b1, 5'd10, 32'd1, 32'h2200, 5'd10, 5'd0);
        cyc(1'b0, 1'b1, 5'd10, 32'd2, 32'h3044, 1'b0, 5'd0, 32'd0, 32'd0, 5'd10, 5'd0);
        chk("t4_pend_before", pend_rs, 1'b1);
        after_edge();
        chk("t4_young_data", grf_data_in, 32'd2);
        idle(5'd10, 5'd10);
        chk("t4_pend_after", pend_rs, 1'b0);
        after_edge();
        chk("t4_dead_pop", grf_write, 1'b0);
        idle(5'd0, 5'd0);

        // Fill the FIFO; the fifth request is held until a pop frees space
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b1, 5'd30, 32'h300 + 32'(i), 32'h3050, 1'b1, 5'd21 + 5'(i),
                32'h100 + 32'(i), 32'h2300 + 32'(i), 5'd21, 5'd24);
        repeat (2) begin
            cyc(1'b0, 1'b1, 5'd30, 32'h310, 32'h3060, 1'b1, 5'd25, 32'h104, 32'h2304,
                5'd25, 5'd22);
            chk("t5_full_ready", md_ready, 1'b0);
        end
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd25, 32'h104, 32'h2304, 5'd25, 5'd0);
        chk("t5_pop_ready", md_ready, 1'b1);
        repeat (6) idle(5'd25, 5'd21);
        chk("t5_fill_writes", seen_fill, 5);

        // Reset with parked entries discards them
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 5'd30, 32'h400, 32'h3070, 1'b1, 5'd14 + 5'(i), 32'h500 + 32'(i),
                32'h2400, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 5'd6, 32'h600, 32'h3080, 1'b1, 5'd17, 32'h700, 32'h2500, 5'd14, 5'd15);
        idle(5'd14, 5'd15);
        chk("t6_pend_rs", pend_rs, 1'b0);
        chk("t6_pend_rt", pend_rt, 1'b0);
        chk("t6_no_write_rst", grf_write, 1'b0);
        after_edge();
        chk("t6_no_write_after", grf_write, 1'b0);
        cyc(1'b0, 1'b1, 5'd0, 32'h800, 32'h3090, 1'b1, 5'd0, 32'h900, 32'h2600, 5'd16, 5'd0);
        chk("t6_zero_md_ack", md_ready, 1'b1);
        after_edge();
        chk("t6_zero_no_write", grf_write, 1'b0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_wb_arb.md
Name: mod_wb_arb

Overview:
- Writer-side front end of the general register file.
- Each cycle it merges two write-back sources into the single GRF write port (grf_write / grf_reg_in / grf_data_in / pc_now):
  - the in-order pipeline WB stage;
  - the out-of-order multi-cycle mult/div unit.
- Mult/div results that lose arbitration are parked in a small FIFO.
- Parked destinations are exported so the hazard unit can stall dependent reads.

Parameters:
- DEPTH, 4: pending-write FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8: cycles a FIFO head may wait before the pipeline is stalled to drain it.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  pipeline write request.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- wb_pc  in  32  PC of the pipeline instruction.
- wb_stall  out  1  the pipeline request is not taken this cycle; upstream holds the WB stage.
- md_valid  in  1  mult/div write request.
- md_reg  in  5  mult/div destination register.
- md_data  in  32  mult/div write data.
- md_pc  in  32  PC of the mult/div instruction.
- md_ready  out  1  the mult/div request is accepted this cycle (FIFO not full).
- rs  in  5  hazard query A.
- rt  in  5  hazard query B.
- pend_rs  out  1  rs matches a live FIFO entry.
- pend_rt  out  1  rt matches a live FIFO entry.
- grf_write  out  1  registered GRF write enable.
- grf_reg_in  out  5  registered GRF write register.
- grf_data_in  out  32  registered GRF write data.
- pc_now  out  32  registered PC of the write.

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - grf_write=0, grf_reg_in=0, grf_data_in=0, pc_now=0.
  - FIFO empty, all valid bits cleared, starve counter 0.
  - Combinational outputs: wb_stall=0, md_ready=1, pend_rs=0, pend_rt=0.
- Reset mid-operation discards all parked writes. No GRF write is issued in the reset cycle or the cycle after.
- Requests to register 0 are dropped at input:
  - They never win a slot and are never pushed.
  - md_ready still acks them.
- Latency: the selected write appears on the grf_* outputs one cycle after its request cycle. The GRF's own same-cycle bypass covers readers.
- Slot selection, evaluated each cycle in priority order:
  1. starve: FIFO head has waited ≥ STARVE_LIMIT cycles. Pop the head; wb_stall=1.
  2. pipe: wb_valid with wb_reg≠0. Issue the pipeline write.
  3. fifo: FIFO non-empty. Pop the head.
  4. direct: md_valid, md_reg≠0, FIFO empty. Issue the mult/div write directly.
  5. idle: grf_write=0 next cycle.
- Popping a squashed (dead) head consumes the slot with grf_write=0.
- md_ready = FIFO not full, or FIFO full and a pop occurs this cycle.
- An accepted md request that is not issued directly is pushed at the tail.
- Push and pop in the same cycle keep occupancy unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- WAW squash, when a pipeline write to R is taken (not stalled):
  - Every live FIFO entry with reg R is marked dead.
  - An md request to R accepted in the same cycle is pushed dead.
  - The younger pipeline value wins.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- pend_rs/pend_rt:
  - Combinational match of rs/rt against live (not dead) FIFO entries.
  - A query of 0 always returns 0.
- FIFO full with no pop: md_ready=0. The md unit must hold its request.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: each cycle a write is issued, simulation prints "%d@%h: $%d <= %h" with time, pc, reg, data. Output is gated by the actual grf_write; nothing prints for dead pops.
- Undefined: no display statements are compiled. Logic is otherwise identical.

Test Plan:
- Reset, then wb_valid reg=5 data=0x1234 pc=0x3000 → next cycle grf_write=1, grf_reg_in=5, grf_data_in=0x1234, pc_now=0x3000.
- md_valid reg=8 data=0xAA with wb_valid reg=9 in the same cycle → reg 9 written first; 0xAA parked (pend_rs=1 for rs=8); reg 8 written in the first cycle without wb_valid.
- Hold wb_valid every cycle with one parked entry, STARVE_LIMIT=8 → 8 cycles of pipeline writes, then wb_stall=1 for one cycle and the parked write issues.
- Park md reg=10 data=1, then pipeline write reg=10 data=2 → entry squashed; only the value 2 reaches reg 10; pend for rs=10 drops to 0.
- Fill all 4 FIFO entries under continuous wb_valid → md_ready=0; the 5th request is held until a pop, and no entry is lost or duplicated.
- Reset asserted with 3 entries parked → FIFO empties, pend outputs 0, no writes; wb_valid reg=0 → grf_write stays 0.
